// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a req/ready handshake to a variable-latency data
// memory, stalls upstream while an access is outstanding and registers the
// MEM->WB values. Optional wait timeout is enabled with MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_d,
    input  logic        mem_m2reg,
    input  logic        mem_wmem,
    input  logic [31:0] S,
    input  logic [31:0] MEM_Alu,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        wb_wreg,
    output logic        wb_m2reg,
    output logic [4:0]  wb_d,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_mdata,
    output logic [15:0] stall_cnt
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        acc, misaligned, is_load, complete, load_wb, err_d;
    logic        wb_wreg_q, wb_m2reg_q, mem_err_q;
    logic [4:0]  wb_d_q;
    logic [31:0] wb_alu_q, wb_mdata_q;
    logic [15:0] stall_cnt_q;

    // A combined load+store is treated as a store and never selects memory data
    assign acc        = mem_m2reg | mem_wmem;
    assign misaligned = acc & (MEM_Alu[1:0] != 2'b00);
    assign is_load    = mem_m2reg & ~mem_wmem;

    assign dm_we    = mem_wmem;
    assign dm_addr  = MEM_Alu;
    assign dm_wdata = S;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_q;
    logic       abort;

    // Wait counter: zero while idle so it starts at 0 on entry to WAIT
    always_ff @(posedge clk) begin
        if (clr || state_q == StIdle) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end
`endif

    // Handshake FSM next state, request and stall generation
    always_comb begin
        state_d   = state_q;
        dm_req    = 1'b0;
        mem_stall = 1'b0;
        complete  = 1'b0;
`ifdef MEM_TIMEOUT_EN
        abort     = 1'b0;
`endif
        if (!clr) begin
            case (state_q)
                StIdle: begin
                    if (acc && !misaligned) begin
                        dm_req = 1'b1;
                        if (dm_ready) begin
                            complete = 1'b1;
                        end else begin
                            mem_stall = 1'b1;
                            state_d   = StWait;
                        end
                    end
                end
                StWait: begin
                    dm_req = 1'b1;
                    if (dm_ready) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end
`ifdef MEM_TIMEOUT_EN
                    // Give up on the access; ready in this same cycle still wins above
                    else if (wait_cnt_q == TimeoutLast) begin
                        abort   = 1'b1;
                        state_d = StIdle;
                    end
`endif
                    else begin
                        mem_stall = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Non-access instructions pass straight through while idle; everything else bubbles
    always_comb begin
        load_wb = complete | ((state_q == StIdle) & ~acc);
        err_d   = (state_q == StIdle) & misaligned;
`ifdef MEM_TIMEOUT_EN
        err_d   = err_d | abort;
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM->WB pipeline registers, error pulse and saturating stall counter
    always_ff @(posedge clk) begin
        if (clr) begin
            wb_wreg_q   <= 1'b0;
            wb_m2reg_q  <= 1'b0;
            wb_d_q      <= 5'd0;
            wb_alu_q    <= 32'd0;
            wb_mdata_q  <= 32'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            mem_err_q <= err_d;
            if (mem_stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (load_wb) begin
                wb_wreg_q  <= mem_wreg;
                wb_m2reg_q <= is_load;
                wb_d_q     <= mem_d;
                wb_alu_q   <= MEM_Alu;
                if (complete && is_load) begin
                    wb_mdata_q <= dm_rdata;
                end
            end else begin
                // Bubble: kill write-back so a stalled instruction is not written twice
                wb_wreg_q  <= 1'b0;
                wb_m2reg_q <= 1'b0;
            end
        end
    end

    assign wb_wreg   = wb_wreg_q;
    assign wb_m2reg  = wb_m2reg_q;
    assign wb_d      = wb_d_q;
    assign wb_alu    = wb_alu_q;
    assign wb_mdata  = wb_mdata_q;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed steps plus randomized instructions,
// checked against a transaction-level model of the MEM stage.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 16;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        mem_wreg, mem_m2reg, mem_wmem;
    logic [4:0]  mem_d;
    logic [31:0] S, MEM_Alu;
    logic        dm_req, dm_we, dm_ready;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_stall, mem_err, wb_wreg, wb_m2reg;
    logic [4:0]  wb_d;
    logic [31:0] wb_alu, wb_mdata;
    logic [15:0] stall_cnt;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .clr       (clr),
        .mem_wreg  (mem_wreg),
        .mem_d     (mem_d),
        .mem_m2reg (mem_m2reg),
        .mem_wmem  (mem_wmem),
        .S         (S),
        .MEM_Alu   (MEM_Alu),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_rdata  (dm_rdata),
        .mem_stall (mem_stall),
        .mem_err   (mem_err),
        .wb_wreg   (wb_wreg),
        .wb_m2reg  (wb_m2reg),
        .wb_d      (wb_d),
        .wb_alu    (wb_alu),
        .wb_mdata  (wb_mdata),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected architectural WB state
    logic        exp_wreg, exp_m2reg, exp_err;
    logic [4:0]  exp_d;
    logic [31:0] exp_alu, exp_mdata;
    int          exp_scnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_wreg  = 1'b0;
        exp_m2reg = 1'b0;
        exp_err   = 1'b0;
        exp_d     = 5'd0;
        exp_alu   = 32'd0;
        exp_mdata = 32'd0;
        exp_scnt  = 0;
    endtask

    task automatic model_bubble(input logic err);
        exp_wreg  = 1'b0;
        exp_m2reg = 1'b0;
        exp_err   = err;
    endtask

    task automatic check_wb(input string ctx);
        chk({ctx, ".wb_wreg"}, 32'(wb_wreg), 32'(exp_wreg));
        chk({ctx, ".wb_m2reg"}, 32'(wb_m2reg), 32'(exp_m2reg));
        chk({ctx, ".wb_d"}, 32'(wb_d), 32'(exp_d));
        chk({ctx, ".wb_alu"}, wb_alu, exp_alu);
        chk({ctx, ".wb_mdata"}, wb_mdata, exp_mdata);
        chk({ctx, ".mem_err"}, 32'(mem_err), 32'(exp_err));
        chk({ctx, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_scnt));
    endtask

    // One instruction through MEM; memory answers after lat not-ready cycles.
    // Called and returns at 1 time unit after a rising edge.
    task automatic run_instr(input string ctx, input logic wreg, input logic [4:0] d,
                             input logic m2reg, input logic wmem, input logic [31:0] s,
                             input logic [31:0] alu, input int lat, input logic [31:0] rdata);
        logic acc, mis, ld, abort, done;
        int   k;
        mem_wreg  = wreg;
        mem_d     = d;
        mem_m2reg = m2reg;
        mem_wmem  = wmem;
        S         = s;
        MEM_Alu   = alu;
        acc = m2reg | wmem;
        mis = acc && (alu[1:0] != 2'b00);
        ld  = m2reg & ~wmem;
        if (!acc || mis) begin
            dm_ready = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
            @(negedge clk);
            chk({ctx, ".dm_req"}, 32'(dm_req), 32'd0);
            chk({ctx, ".mem_stall"}, 32'(mem_stall), 32'd0);
            @(posedge clk);
            #1;
            if (mis) begin
                model_bubble(1'b1);
            end else begin
                exp_wreg  = wreg;
                exp_m2reg = 1'b0;
                exp_d     = d;
                exp_alu   = alu;
                exp_err   = 1'b0;
            end
            check_wb(ctx);
        end else begin
            k    = 0;
            done = 1'b0;
            while (!done) begin
                dm_ready = (k == lat);
                dm_rdata = (k == lat) ? rdata : $urandom;
`ifdef MEM_TIMEOUT_EN
                abort = (k == int'(TO)) && (lat > int'(TO));
`else
                abort = 1'b0;
`endif
                @(negedge clk);
                chk({ctx, ".dm_req"}, 32'(dm_req), 32'd1);
                chk({ctx, ".dm_we"}, 32'(dm_we), 32'(wmem));
                chk({ctx, ".dm_addr"}, dm_addr, alu);
                chk({ctx, ".dm_wdata"}, dm_wdata, s);
                chk({ctx, ".mem_stall"}, 32'(mem_stall), 32'((k < lat) && !abort));
                @(posedge clk);
                #1;
                if (k == lat) begin
                    exp_wreg  = wreg;
                    exp_m2reg = ld;
                    exp_d     = d;
                    exp_alu   = alu;
                    exp_err   = 1'b0;
                    if (ld) exp_mdata = rdata;
                    done = 1'b1;
                end else if (abort) begin
                    model_bubble(1'b1);
                    done = 1'b1;
                end else begin
                    model_bubble(1'b0);
                    if (exp_scnt < 65535) exp_scnt++;
                end
                if (lat < 200 || done) check_wb(ctx);
                k++;
            end
        end
        dm_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r_alu, r_pick;
        // Reset with a pending aligned load on the inputs: no request may escape
        clr       = 1'b1;
        mem_wreg  = 1'b1;
        mem_d     = 5'd3;
        mem_m2reg = 1'b1;
        mem_wmem  = 1'b0;
        S         = 32'h0;
        MEM_Alu   = 32'h40;
        dm_ready  = 1'b0;
        dm_rdata  = 32'h0;
        @(posedge clk);
        @(negedge clk);
        chk("reset.dm_req", 32'(dm_req), 32'd0);
        chk("reset.mem_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        check_wb("reset");
        clr = 1'b0;

        run_instr("alu_op", 1'b1, 5'd5, 1'b0, 1'b0, 32'h0, 32'h1234, 0, 32'h0);
        run_instr("load_fast", 1'b1, 5'd7, 1'b1, 1'b0, 32'h0, 32'h40, 0, 32'hDEADBEEF);
        run_instr("store_slow", 1'b0, 5'd0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h80, 3, 32'h0);
        chk("store_slow.cnt3", 32'(stall_cnt), 32'd3);
        run_instr("ld_and_st", 1'b1, 5'd9, 1'b1, 1'b1, 32'h11112222, 32'h84, 1, 32'h5555AAAA);
        run_instr("misaligned", 1'b1, 5'd2, 1'b1, 1'b0, 32'h0, 32'h42, 0, 32'h0);
        run_instr("after_mis", 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 32'h99, 0, 32'h0);

        // Reset two cycles into a slow load
        mem_wreg  = 1'b1;
        mem_d     = 5'd6;
        mem_m2reg = 1'b1;
        mem_wmem  = 1'b0;
        MEM_Alu   = 32'h200;
        dm_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b1;
        @(negedge clk);
        chk("rst_wait.dm_req", 32'(dm_req), 32'd0);
        chk("rst_wait.mem_stall", 32'(mem_stall), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        check_wb("rst_wait");
        clr = 1'b0;
        run_instr("post_rst", 1'b1, 5'd1, 1'b0, 1'b0, 32'h0, 32'h10, 0, 32'h0);

`ifdef MEM_TIMEOUT_EN
        run_instr("timeout", 1'b1, 5'd8, 1'b1, 1'b0, 32'h0, 32'h300, 1000, 32'h0);
        chk("timeout.cnt", 32'(stall_cnt), 32'(TO));
        run_instr("after_to", 1'b1, 5'd8, 1'b0, 1'b0, 32'h0, 32'h304, 0, 32'h0);
`endif

        for (int i = 0; i < 150; i++) begin
            r_alu  = $urandom;
            r_pick = $urandom;
            if (r_pick[1:0] != 2'b00) r_alu[1:0] = 2'b00;
            run_instr("random", r_pick[2], r_pick[7:3], r_pick[8], r_pick[9] & r_pick[10],
                      $urandom, r_alu, $urandom_range(0, 4), $urandom);
        end

`ifndef MEM_TIMEOUT_EN
        // Long wait pushes the stall counter into saturation
        run_instr("saturate", 1'b1, 5'd12, 1'b1, 1'b0, 32'h0, 32'h400, 65600, 32'hCAFEF00D);
        chk("saturate.cnt", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
